// File: rtl/cc_mim_pkg.sv
// Shared definitions for the micro-sequencer: MIR field map, COND codes, FSM encoding.
// Latency/backpressure: none (package only).
package cc_mim_pkg;

  localparam int MIR_W    = 41;
  localparam int CSADDR_W = 11;
  localparam int IR_W     = 32;
  localparam int PSR_W    = 4;

  // MIR field positions, bit 40 down to 0
  localparam int A_LSB    = 35;
  localparam int A_W      = 6;
  localparam int AMUX_BIT = 34;
  localparam int B_LSB    = 28;
  localparam int B_W      = 6;
  localparam int BMUX_BIT = 27;
  localparam int C_LSB    = 21;
  localparam int C_W      = 6;
  localparam int CMUX_BIT = 20;
  localparam int RD_BIT   = 19;
  localparam int WR_BIT   = 18;
  localparam int ALU_LSB  = 14;
  localparam int ALU_W    = 4;
  localparam int COND_LSB = 11;
  localparam int COND_W   = 3;
  localparam int JUMP_LSB = 0;
  localparam int JUMP_W   = 11;

  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  // Decode-address construction: {1, op, op3, 00}
  localparam int       IR_BRANCH_BIT = 13;
  localparam int       IR_OP_HI      = 31;
  localparam int       IR_OP_LO      = 30;
  localparam int       IR_OP3_HI     = 24;
  localparam int       IR_OP3_LO     = 19;
  localparam logic     DEC_PREFIX    = 1'b1;
  localparam logic [1:0] DEC_SUFFIX  = 2'b00;

  typedef enum logic [COND_W-1:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [CSADDR_W-1:0] decode_addr(input logic [IR_W-1:0] ir);
    return {DEC_PREFIX, ir[IR_OP_HI:IR_OP_LO], ir[IR_OP3_HI:IR_OP3_LO], DEC_SUFFIX};
  endfunction

endpackage

// File: rtl/cc_mim_next_address.sv
// Next control-store address from COND/JUMP, PSR flags and IR.
// Latency: combinational; backpressure: none.
module cc_mim_next_address
  import cc_mim_pkg::*;
(
  input  logic [CSADDR_W-1:0] upc,
  input  logic [COND_W-1:0]   cond,
  input  logic [JUMP_W-1:0]   jump,
  input  logic [PSR_W-1:0]    psr,
  input  logic [IR_W-1:0]     ir,
  output logic [CSADDR_W-1:0] next_addr
);

  logic [CSADDR_W-1:0] upc_inc;
  logic                taken;
  logic                unused_ir;

  // Only op, op3 and the branch bit of the IR steer the sequence
  assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

  always_comb begin
    upc_inc   = upc + 1'b1;
    taken     = 1'b0;
    next_addr = upc_inc;
    case (cond_e'(cond))
      COND_NEXT:   taken = 1'b0;
      COND_N:      taken = psr[PSR_N];
      COND_Z:      taken = psr[PSR_Z];
      COND_V:      taken = psr[PSR_V];
      COND_C:      taken = psr[PSR_C];
      COND_IR13:   taken = ir[IR_BRANCH_BIT];
      COND_JUMP:   taken = 1'b1;
      COND_DECODE: taken = 1'b0;
      default:     taken = 1'b0;
    endcase
    if (cond_e'(cond) == COND_DECODE)
      next_addr = decode_addr(ir);
    else if (taken)
      next_addr = jump;
  end

endmodule

// File: rtl/cc_mim_microsequencer.sv
// Micro-PC/MIR sequencer in front of the control store; FETCH -> EXEC [-> WAIT] -> FETCH.
// Latency: 2 cycles per microword, plus one per MemReady-low cycle on RD/WR words.
module cc_mim_microsequencer
  import cc_mim_pkg::*;
#(
  parameter int                         DATAWIDTH_MIR    = 41,
  parameter int                         DATAWIDTH_CSADDR = 11,
  parameter int                         DATAWIDTH_IR     = 32,
  parameter logic [DATAWIDTH_CSADDR-1:0] RESET_ADDR      = 11'd0
) (
  input  logic                        CC_MIM_Microsequencer_CLOCK_50,
  input  logic                        CC_MIM_Microsequencer_RESET_InLow,
  output logic [DATAWIDTH_CSADDR-1:0] CC_MIM_Microsequencer_CSAddress_data_OutBUS,
  input  logic [DATAWIDTH_MIR-1:0]    CC_MIM_Microsequencer_CSData_data_InBUS,
  input  logic [DATAWIDTH_IR-1:0]     CC_MIM_Microsequencer_IR_data_InBUS,
  input  logic [3:0]                  CC_MIM_Microsequencer_PSR_data_InBUS,
  input  logic                        CC_MIM_Microsequencer_MemReady_InHigh,
  output logic [DATAWIDTH_MIR-1:0]    CC_MIM_Microsequencer_MIR_data_OutBUS,
  output logic                        CC_MIM_Microsequencer_Commit_OutHigh,
  output logic                        CC_MIM_Microsequencer_MemWait_OutHigh
);

  state_e                      state, state_nxt;
  logic [DATAWIDTH_CSADDR-1:0] upc;
  logic [DATAWIDTH_MIR-1:0]    mir;
  logic [DATAWIDTH_CSADDR-1:0] next_addr;
  logic                        mir_load;
  logic                        commit;
  logic                        mem_wait;
  logic                        mem_access;

  assign mem_access = mir[RD_BIT] | mir[WR_BIT];

  cc_mim_next_address u_next_address (
    .upc       (upc),
    .cond      (mir[COND_LSB +: COND_W]),
    .jump      (mir[JUMP_LSB +: JUMP_W]),
    .psr       (CC_MIM_Microsequencer_PSR_data_InBUS),
    .ir        (CC_MIM_Microsequencer_IR_data_InBUS),
    .next_addr (next_addr)
  );

  always_ff @(posedge CC_MIM_Microsequencer_CLOCK_50) begin
    if (!CC_MIM_Microsequencer_RESET_InLow) begin
      state <= ST_FETCH;
      upc   <= RESET_ADDR;
      mir   <= '0;
    end else begin
      state <= state_nxt;
      if (mir_load) mir <= CC_MIM_Microsequencer_CSData_data_InBUS;
      if (commit)   upc <= next_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    mir_load  = 1'b0;
    commit    = 1'b0;
    mem_wait  = 1'b0;
    case (state)
      ST_FETCH: begin
        mir_load  = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (!mem_access || CC_MIM_Microsequencer_MemReady_InHigh) begin
          commit    = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_wait = 1'b1;
        if (CC_MIM_Microsequencer_MemReady_InHigh) begin
          commit    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
    // A reset landing on this edge aborts the microinstruction, so it must not commit
    if (!CC_MIM_Microsequencer_RESET_InLow)
      commit = 1'b0;
  end

  assign CC_MIM_Microsequencer_CSAddress_data_OutBUS = upc;
  assign CC_MIM_Microsequencer_MIR_data_OutBUS       = mir;
  assign CC_MIM_Microsequencer_Commit_OutHigh        = commit;
  assign CC_MIM_Microsequencer_MemWait_OutHigh       = mem_wait;

endmodule

// File: tb/tb_cc_mim_microsequencer.sv
// Directed bench for the micro-sequencer: sequencing, branch conditions, memory stall, reset abort.
module tb_cc_mim_microsequencer;

  logic        clk;
  logic        rst_n;
  logic [10:0] cs_addr;
  logic [40:0] cs_data;
  logic [31:0] ir;
  logic [3:0]  psr;
  logic        mem_ready;
  logic [40:0] mir;
  logic        commit;
  logic        mem_wait;

  int checks   = 0;
  int failures = 0;

  cc_mim_microsequencer dut (
    .CC_MIM_Microsequencer_CLOCK_50            (clk),
    .CC_MIM_Microsequencer_RESET_InLow         (rst_n),
    .CC_MIM_Microsequencer_CSAddress_data_OutBUS(cs_addr),
    .CC_MIM_Microsequencer_CSData_data_InBUS   (cs_data),
    .CC_MIM_Microsequencer_IR_data_InBUS       (ir),
    .CC_MIM_Microsequencer_PSR_data_InBUS      (psr),
    .CC_MIM_Microsequencer_MemReady_InHigh     (mem_ready),
    .CC_MIM_Microsequencer_MIR_data_OutBUS     (mir),
    .CC_MIM_Microsequencer_Commit_OutHigh      (commit),
    .CC_MIM_Microsequencer_MemWait_OutHigh     (mem_wait)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Microword with fixed, non-zero datapath fields so the whole MIR is exercised
  function automatic logic [40:0] mk_word(input logic rd, input logic wr,
                                          input logic [2:0] cond, input logic [10:0] jump);
    return {6'h2A, 1'b1, 6'h15, 1'b0, 6'h33, 1'b1, rd, wr, 4'hA, cond, jump};
  endfunction

  // Entered just after an edge with the sequencer in FETCH; runs one non-memory word
  task automatic run_instr(input string tag, input logic [40:0] w, input logic [10:0] exp_upc);
    cs_data = w;
    #1;
    check({tag, "_fetch_commit"}, {63'd0, commit}, 64'd0);
    tick();
    check({tag, "_mir"}, {23'd0, mir}, {23'd0, w});
    check({tag, "_exec_commit"}, {63'd0, commit}, 64'd1);
    tick();
    check({tag, "_upc"}, {53'd0, cs_addr}, {53'd0, exp_upc});
  endtask

  logic [40:0] w;

  initial begin
    rst_n     = 1'b0;
    cs_data   = mk_word(1'b0, 1'b0, 3'b000, 11'd0);
    ir        = 32'd0;
    psr       = 4'd0;
    mem_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_upc", {53'd0, cs_addr}, 64'd0);
    check("rst_mir", {23'd0, mir}, 64'd0);
    check("rst_commit", {63'd0, commit}, 64'd0);
    check("rst_memwait", {63'd0, mem_wait}, 64'd0);
    rst_n = 1'b1;

    // Sequential: 0 -> 1, commit only in the second cycle
    run_instr("seq", mk_word(1'b0, 1'b0, 3'b000, 11'd55), 11'd1);
    check("seq_commit_after", {63'd0, commit}, 64'd0);

    // Decode: op=10, op3=010000 -> 1600
    ir = 32'h8080_0000;
    run_instr("decode", mk_word(1'b0, 1'b0, 3'b111, 11'd3), 11'd1600);

    // IR[13] branch taken, then not taken
    ir = 32'h0000_2000;
    run_instr("ir13_t", mk_word(1'b0, 1'b0, 3'b101, 11'd1602), 11'd1602);
    ir = 32'h0000_0000;
    run_instr("ir13_nt", mk_word(1'b0, 1'b0, 3'b101, 11'd5), 11'd1603);

    // Wrap at 2047, then flag-conditioned branches
    run_instr("jump", mk_word(1'b0, 1'b0, 3'b110, 11'd2047), 11'd2047);
    run_instr("wrap", mk_word(1'b0, 1'b0, 3'b000, 11'd700), 11'd0);
    psr = 4'b0100;
    run_instr("z_t", mk_word(1'b0, 1'b0, 3'b010, 11'd12), 11'd12);
    psr = 4'b1011;
    run_instr("z_nt", mk_word(1'b0, 1'b0, 3'b010, 11'd100), 11'd13);
    psr = 4'b1000;
    run_instr("n_t", mk_word(1'b0, 1'b0, 3'b001, 11'd300), 11'd300);
    psr = 4'b0001;
    run_instr("v_nt", mk_word(1'b0, 1'b0, 3'b011, 11'd9), 11'd301);
    run_instr("c_t", mk_word(1'b0, 1'b0, 3'b100, 11'd8), 11'd8);
    psr = 4'b0010;
    run_instr("v_t", mk_word(1'b0, 1'b0, 3'b011, 11'd20), 11'd20);

    // Read stalled for 3 cycles of MemReady low; MemReady high in FETCH must be ignored
    w         = mk_word(1'b1, 1'b0, 3'b000, 11'd77);
    cs_data   = w;
    mem_ready = 1'b1;
    #1;
    check("rd_fetch_commit", {63'd0, commit}, 64'd0);
    tick();
    mem_ready = 1'b0;
    cs_data   = mk_word(1'b0, 1'b0, 3'b110, 11'd999);
    #1;
    check("rd_exec_commit", {63'd0, commit}, 64'd0);
    check("rd_exec_memwait", {63'd0, mem_wait}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rd_wait_memwait", {63'd0, mem_wait}, 64'd1);
      check("rd_wait_commit", {63'd0, commit}, 64'd0);
      check("rd_wait_mir", {23'd0, mir}, {23'd0, w});
      check("rd_wait_upc", {53'd0, cs_addr}, 64'd20);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check("rd_ready_memwait", {63'd0, mem_wait}, 64'd1);
    check("rd_ready_commit", {63'd0, commit}, 64'd1);
    check("rd_ready_mir", {23'd0, mir}, {23'd0, w});
    tick();
    mem_ready = 1'b0;
    #1;
    check("rd_done_upc", {53'd0, cs_addr}, 64'd21);
    check("rd_done_commit", {63'd0, commit}, 64'd0);
    check("rd_done_memwait", {63'd0, mem_wait}, 64'd0);

    // RD and WR together with ready already high: one access, no stall
    mem_ready = 1'b1;
    run_instr("rdwr", mk_word(1'b1, 1'b1, 3'b000, 11'd4), 11'd22);
    mem_ready = 1'b0;

    // Write stalled into WAIT, then reset: aborted with no commit
    w       = mk_word(1'b0, 1'b1, 3'b110, 11'd500);
    cs_data = w;
    tick();
    tick();
    check("wr_wait_memwait", {63'd0, mem_wait}, 64'd1);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rstw_commit", {63'd0, commit}, 64'd0);
    tick();
    check("rstw_upc", {53'd0, cs_addr}, 64'd0);
    check("rstw_mir", {23'd0, mir}, 64'd0);
    check("rstw_memwait", {63'd0, mem_wait}, 64'd0);
    check("rstw_commit_after", {63'd0, commit}, 64'd0);
    rst_n     = 1'b1;
    mem_ready = 1'b0;

    // Sequencing restarts cleanly from address 0
    run_instr("restart", mk_word(1'b0, 1'b0, 3'b000, 11'd0), 11'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_mim_microsequencer.md
Name: cc_mim_microsequencer

Overview:
- Micro-program sequencer that sits directly upstream of the control store ROM.
- Holds the micro-PC that drives the control store address. Latches the returned 41-bit microword into the MIR and drives it to the datapath.
- Computes the next control-store address from the MIR COND/JUMP fields, the PSR flags and the IR.
- Stalls the sequence while a memory read/write microinstruction waits for the memory ready handshake.

Parameters:
- DATAWIDTH_MIR, 41, microword width (control store output).
- DATAWIDTH_CSADDR, 11, control store address width.
- DATAWIDTH_IR, 32, instruction register width.
- RESET_ADDR, 11'd0, micro-PC value after reset.

Ports:
- CC_MIM_Microsequencer_CLOCK_50  input  1  single system clock; all state changes on rising edge.
- CC_MIM_Microsequencer_RESET_InLow  input  1  synchronous, active-low reset.
- CC_MIM_Microsequencer_CSAddress_data_OutBUS  output  11  registered micro-PC; drives the control store address.
- CC_MIM_Microsequencer_CSData_data_InBUS  input  41  microword returned combinationally by the control store.
- CC_MIM_Microsequencer_IR_data_InBUS  input  32  current instruction register.
- CC_MIM_Microsequencer_PSR_data_InBUS  input  4  flags {n,z,v,c}, bit3=n ... bit0=c.
- CC_MIM_Microsequencer_MemReady_InHigh  input  1  memory completed the current read/write.
- CC_MIM_Microsequencer_MIR_data_OutBUS  output  41  registered microinstruction to the datapath.
- CC_MIM_Microsequencer_Commit_OutHigh  output  1  one-cycle strobe; the datapath writes register C / the PSR only on this cycle.
- CC_MIM_Microsequencer_MemWait_OutHigh  output  1  high while stalled in WAIT.

Behaviour:
- Reset is sampled only on the rising clock edge while RESET_InLow is 0. On reset:
  - uPC = RESET_ADDR, MIR = 0.
  - state = FETCH.
  - Commit = 0, MemWait = 0.
- Reset asserted mid-WAIT or mid-EXEC aborts the current microinstruction; no Commit is issued.
- MIR field map, bit 40 down to 0:
  - A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20].
  - RD[19], WR[18], ALU[17:14], COND[13:11], JUMP[10:0].
- FSM states: FETCH, EXEC, WAIT.
  - FETCH: MIR <= CSData_InBUS; go to EXEC. Commit = 0.
  - EXEC, no memory access (RD=0 and WR=0), or memory access with MemReady=1: Commit = 1; uPC <= next address; go to FETCH.
  - EXEC, RD or WR set with MemReady=0: go to WAIT. uPC and MIR hold. Commit = 0.
  - WAIT: MemWait = 1. On MemReady=1: Commit = 1, uPC <= next address, go to FETCH. Otherwise hold.
- Latency: 2 cycles per non-memory microinstruction. Memory microinstructions take 2 + number of cycles with MemReady low.
- Next address is evaluated from the MIR, PSR and IR values in the committing cycle. COND decoding:
  - 000: uPC+1, modulo 2048 (2047 wraps to 0).
  - 001: JUMP if n, else uPC+1.
  - 010: JUMP if z, else uPC+1.
  - 011: JUMP if v, else uPC+1.
  - 100: JUMP if c, else uPC+1.
  - 101: JUMP if IR[13], else uPC+1.
  - 110: JUMP unconditionally.
  - 111: decode, next = {1'b1, IR[31:30], IR[24:19], 2'b00}.
- Commit and MemWait are combinational from state/MIR/MemReady. The MIR and address outputs are registered.
- RD and WR both set is treated as a single memory access, one MemReady.
- MemReady during FETCH is ignored.

Decomposition:
- Shared package cc_mim_pkg holds:
  - MIR field bit positions and widths.
  - COND codes (COND_NEXT ... COND_DECODE).
  - FSM state encoding.
  - Decode-address construction constants.
- One combinational sub-module, cc_mim_next_address: inputs uPC, COND, JUMP, PSR, IR; output 11-bit next address.

Test Plan:
- Reset then release, control store returns word with COND=000:
  - uPC 0 -> 1 after 2 cycles.
  - Commit pulses once, in cycle 2.
- MIR COND=111, IR=0x80800000 (op=10, op3=010000) -> next uPC = 11'd1600 (0b11001000000).
- MIR COND=101, JUMP=1602, IR[13]=1 -> uPC=1602. Repeat with IR[13]=0 -> uPC = current+1.
- MIR RD=1, MemReady low 3 cycles then high:
  - MemWait high 3 cycles.
  - Single Commit pulse on the ready cycle; MIR stable throughout.
- uPC=2047, COND=000 -> uPC=0. COND=010, z=1, JUMP=12 -> uPC=12.
- Reset asserted during WAIT:
  - Next cycle uPC=0, MIR=0, MemWait=0.
  - No Commit pulse.
